// File: rtl/seg7_tdm_scanner_if.sv
// Load handshake and display pin bundle for seg7_tdm_scanner.
// master = user logic / board side, slave = the scanner.
interface seg7_tdm_scanner_if #(
    parameter int DIGITS = 4,
    parameter int DATA_W = 8
);
    logic              load;
    logic [DATA_W-1:0] data_in;
    logic              busy;
    logic              overflow;
    logic [DIGITS-1:0] AN;
    logic [6:0]        seg;
    logic [3:0]        digit_val;

    modport master (
        output load, data_in,
        input  busy, overflow, AN, seg, digit_val
    );

    modport slave (
        input  load, data_in,
        output busy, overflow, AN, seg, digit_val
    );
endinterface

// File: rtl/seg7_tdm_scanner.sv
// TDM seven-segment scanner with sequential double-dabble conversion,
// leading-zero blanking and overflow dash display.
module seg7_tdm_scanner #(
    parameter int DIGITS   = 4,
    parameter int DATA_W   = 8,
    parameter int PRESCALE = 16,
    parameter int BLANK_LZ = 1
) (
    input logic               clk,
    input logic               rst_n,
    seg7_tdm_scanner_if.slave bus
);

    // Decimal digits needed to hold 2^w - 1.
    function automatic int dec_digits(input int w);
        longint v;
        int     n;
        v = (longint'(1) << w) - 1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            if (v > 0) begin
                v = v / 10;
                n = n + 1;
            end
        end
        return (n < 1) ? 1 : n;
    endfunction

    function automatic logic [6:0] dec7(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    localparam int BCD_N = dec_digits(DATA_W);
    localparam int SCR_N = (BCD_N > DIGITS) ? BCD_N : DIGITS;
    localparam int CW    = $clog2(DATA_W + 1);
    localparam int PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CONV = 1'b1;

    localparam logic [6:0] DASH = 7'b0111111;
    localparam logic [6:0] OFF  = 7'b1111111;

    logic [0:0]          state;
    logic [DATA_W-1:0]   shreg;
    logic [4*SCR_N-1:0]  scratch;
    logic [CW-1:0]       iter;
    logic [4*DIGITS-1:0] disp;
    logic                ovf;
    logic [PW-1:0]       presc;
    logic [SW-1:0]       slot;
    logic [DIGITS-1:0]   an_q;
    logic [6:0]          seg_q;
    logic [3:0]          dv_q;

    logic [4*SCR_N-1:0]  adj;
    logic [4*SCR_N-1:0]  scr_next;
    logic [DATA_W-1:0]   sh_next;
    logic                ovf_next;

    logic [3:0]          nib;
    logic                lz;
    logic                blank;
    logic [DIGITS-1:0]   an_n;
    logic [6:0]          seg_n;

    // One double-dabble step: add-3 on large nibbles, then shift in the next bit.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < SCR_N; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        scr_next = (4*SCR_N)'({adj, shreg[DATA_W-1]});
        sh_next  = {shreg[DATA_W-2:0], 1'b0};
        ovf_next = 1'b0;
        for (int i = DIGITS; i < SCR_N; i++) begin
            if (scr_next[4*i +: 4] != 4'd0) begin
                ovf_next = 1'b1;
            end
        end
    end

    // Conversion FSM; the display register only changes on the final step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            scratch <= '0;
            iter    <= '0;
            disp    <= '0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        shreg   <= bus.data_in;
                        scratch <= '0;
                        iter    <= '0;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    shreg   <= sh_next;
                    scratch <= scr_next;
                    iter    <= iter + CW'(1);
                    if (iter == CW'(DATA_W - 1)) begin
                        disp  <= scr_next[4*DIGITS-1:0];
                        ovf   <= ovf_next;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Free-running slot timer, independent of conversion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
            slot  <= '0;
        end else if (presc == PW'(PRESCALE - 1)) begin
            presc <= '0;
            slot  <= (slot == SW'(DIGITS - 1)) ? '0 : slot + SW'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Pick the current slot's nibble and decide blank / dash / digit.
    always_comb begin
        nib  = '0;
        lz   = 1'b1;
        an_n = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (slot == SW'(i)) begin
                nib     = disp[4*i +: 4];
                an_n[i] = 1'b0;
            end
            if (SW'(i) >= slot && disp[4*i +: 4] != 4'd0) begin
                lz = 1'b0;
            end
        end
        blank = (BLANK_LZ != 0) && !ovf && (slot != '0) && lz;
        if (blank) begin
            an_n = '1;
        end
        if (ovf) begin
            seg_n = DASH;
        end else if (blank) begin
            seg_n = OFF;
        end else begin
            seg_n = dec7(nib);
        end
    end

    // Register the pin drive so AN/seg change cleanly one cycle after the slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_q  <= '1;
            seg_q <= OFF;
            dv_q  <= '0;
        end else begin
            an_q  <= an_n;
            seg_q <= seg_n;
            dv_q  <= nib;
        end
    end

    assign bus.busy      = (state == CONV);
    assign bus.overflow  = ovf;
    assign bus.AN        = an_q;
    assign bus.seg       = seg_q;
    assign bus.digit_val = dv_q;

endmodule

// File: tb/tb_seg7_tdm_scanner.sv
// Bench for seg7_tdm_scanner: three instances (8-bit blanked,
// 16-bit blanked, 8-bit unblanked), checked against a decimal model.
module tb_seg7_tdm_scanner;

    localparam int PS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   k = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    // Edges seen since reset was released.
    always @(posedge clk) k <= rst_n ? k + 1 : 0;

    seg7_tdm_scanner_if #(.DIGITS(4), .DATA_W(8))  b8 ();
    seg7_tdm_scanner_if #(.DIGITS(4), .DATA_W(16)) b16 ();
    seg7_tdm_scanner_if #(.DIGITS(4), .DATA_W(8))  bn ();

    seg7_tdm_scanner #(
        .DIGITS(4), .DATA_W(8), .PRESCALE(PS), .BLANK_LZ(1)
    ) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));

    seg7_tdm_scanner #(
        .DIGITS(4), .DATA_W(16), .PRESCALE(PS), .BLANK_LZ(1)
    ) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));

    seg7_tdm_scanner #(
        .DIGITS(4), .DATA_W(8), .PRESCALE(PS), .BLANK_LZ(0)
    ) un (.clk(clk), .rst_n(rst_n), .bus(bn));

    logic [6:0] pats [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    // Expected pins for a decimal value v on a 4-digit display.
    function automatic void model(
        input int v, input int s, input bit blz,
        output logic [3:0] an, output logic [6:0] sg,
        output logic [3:0] dv, output logic ov
    );
        int p;
        bit blank;
        p = 1;
        for (int j = 0; j < s; j++) p = p * 10;
        ov    = (v >= 10000);
        dv    = 4'((v / p) % 10);
        blank = blz && !ov && (s > 0) && (v < p);
        an    = blank ? 4'hF : ~(4'b0001 << s);
        if (ov) sg = 7'b0111111;
        else if (blank) sg = 7'b1111111;
        else sg = pats[dv];
    endfunction

    task automatic sample(
        input int w,
        output logic [3:0] an, output logic [6:0] sg,
        output logic [3:0] dv, output logic ov, output logic bs
    );
        case (w)
            0: begin
                an = b8.AN; sg = b8.seg; dv = b8.digit_val;
                ov = b8.overflow; bs = b8.busy;
            end
            1: begin
                an = b16.AN; sg = b16.seg; dv = b16.digit_val;
                ov = b16.overflow; bs = b16.busy;
            end
            default: begin
                an = bn.AN; sg = bn.seg; dv = bn.digit_val;
                ov = bn.overflow; bs = bn.busy;
            end
        endcase
    endtask

    task automatic set_load(input int w, input bit ld, input int val);
        case (w)
            0: begin b8.load = ld; b8.data_in = 8'(val); end
            1: begin b16.load = ld; b16.data_in = 16'(val); end
            default: begin bn.load = ld; bn.data_in = 8'(val); end
        endcase
    endtask

    // One-cycle load pulse; returns on the negedge after the accepting edge.
    task automatic do_load(input int w, input int val);
        @(negedge clk);
        set_load(w, 1'b1, val);
        @(negedge clk);
        set_load(w, 1'b0, 0);
    endtask

    task automatic wait_idle(input int w);
        logic [3:0] an;
        logic [6:0] sg;
        logic [3:0] dv;
        logic ov, bs;
        int n;
        n = 0;
        sample(w, an, sg, dv, ov, bs);
        while (bs === 1'b1 && n < 60) begin
            @(negedge clk);
            sample(w, an, sg, dv, ov, bs);
            n++;
        end
        if (bs !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL busy_timeout inst=%0d busy=%b want 0", w, bs);
        end
    endtask

    task automatic test_reset();
        logic [3:0] an, ean;
        logic [6:0] sg, esg;
        logic [3:0] dv, edv;
        logic ov, eov, bs;
        int s;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        sample(0, an, sg, dv, ov, bs);
        vectors++;
        if ({an, sg, dv, ov, bs} !== {4'hF, 7'h7F, 4'h0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state AN=%b seg=%b dv=%0d ov=%b busy=%b want 1111 1111111 0 0 0",
                     an, sg, dv, ov, bs);
        end
        rst_n = 1'b1;
        for (int w = 0; w < 3; w += 2) begin
            for (int c = 0; c < 4 * PS; c++) begin
                @(negedge clk);
                s = ((k - 1) / PS) % 4;
                model(0, s, w == 0, ean, esg, edv, eov);
                sample(w, an, sg, dv, ov, bs);
                vectors++;
                if ({an, sg, dv, ov, bs} !== {ean, esg, edv, eov, 1'b0}) begin
                    miscompares++;
                    $display("FAIL reset_scan inst=%0d k=%0d AN=%b seg=%b want AN=%b seg=%b",
                             w, k, an, sg, ean, esg);
                end
            end
        end
    endtask

    task automatic test_conv_busy();
        logic [3:0] an, ean;
        logic [6:0] sg, esg;
        logic [3:0] dv, edv;
        logic ov, eov, bs;
        int s;
        do_load(0, 255);
        for (int c = 0; c < 8; c++) begin
            vectors++;
            if (b8.busy !== 1'b1) begin
                miscompares++;
                $display("FAIL busy_high cycle=%0d busy=%b want 1", c, b8.busy);
            end
            @(negedge clk);
        end
        vectors++;
        if (b8.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_fall busy=%b want 0", b8.busy);
        end
        for (int c = 0; c < 4 * PS; c++) begin
            @(negedge clk);
            s = ((k - 1) / PS) % 4;
            model(255, s, 1'b1, ean, esg, edv, eov);
            sample(0, an, sg, dv, ov, bs);
            vectors++;
            if ({an, sg, dv, ov, bs} !== {ean, esg, edv, eov, 1'b0}) begin
                miscompares++;
                $display("FAIL scan_255 slot=%0d AN=%b seg=%b dv=%0d want AN=%b seg=%b dv=%0d",
                         s, an, sg, dv, ean, esg, edv);
            end
        end
    endtask

    task automatic test_blanking();
        logic [3:0] an, ean;
        logic [6:0] sg, esg;
        logic [3:0] dv, edv;
        logic ov, eov, bs;
        int s, v, w;
        int fixed [6] = '{7, 100, 7, 0, 90, 205};
        int inst  [6] = '{0, 0, 2, 0, 2, 0};
        for (int t = 0; t < 14; t++) begin
            if (t < 6) begin
                v = fixed[t];
                w = inst[t];
            end else begin
                v = $urandom_range(0, 255);
                w = (t % 2 == 0) ? 0 : 2;
            end
            do_load(w, v);
            wait_idle(w);
            for (int c = 0; c < 4 * PS; c++) begin
                @(negedge clk);
                s = ((k - 1) / PS) % 4;
                model(v, s, w == 0, ean, esg, edv, eov);
                sample(w, an, sg, dv, ov, bs);
                vectors++;
                if ({an, sg, dv, ov, bs} !== {ean, esg, edv, eov, 1'b0}) begin
                    miscompares++;
                    $display("FAIL blank_scan inst=%0d v=%0d slot=%0d AN=%b seg=%b dv=%0d want AN=%b seg=%b dv=%0d",
                             w, v, s, an, sg, dv, ean, esg, edv);
                end
            end
        end
    endtask

    task automatic test_load_ignored();
        logic [3:0] an, ean;
        logic [6:0] sg, esg;
        logic [3:0] dv, edv;
        logic ov, eov, bs;
        int s, n;
        do_load(0, 200);
        repeat (2) @(negedge clk);
        b8.load = 1'b1;
        b8.data_in = 8'd50;
        vectors++;
        if (b8.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_during_pulse busy=%b want 1", b8.busy);
        end
        @(negedge clk);
        b8.load = 1'b0;
        n = 3;
        while (b8.busy === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n != 8) begin
            miscompares++;
            $display("FAIL ignored_busy_len got=%0d want 8", n);
        end
        for (int c = 0; c < 4 * PS + 2; c++) begin
            @(negedge clk);
            s = ((k - 1) / PS) % 4;
            model(200, s, 1'b1, ean, esg, edv, eov);
            sample(0, an, sg, dv, ov, bs);
            vectors++;
            if ({an, sg, dv, ov, bs} !== {ean, esg, edv, eov, 1'b0}) begin
                miscompares++;
                $display("FAIL ignore_scan slot=%0d AN=%b seg=%b dv=%0d busy=%b want AN=%b seg=%b dv=%0d",
                         s, an, sg, dv, bs, ean, esg, edv);
            end
        end
    endtask

    task automatic test_overflow();
        logic [3:0] an, ean;
        logic [6:0] sg, esg;
        logic [3:0] dv, edv;
        logic ov, eov, bs;
        int s, v;
        int fixed [4] = '{12345, 9999, 10000, 65535};
        for (int t = 0; t < 8; t++) begin
            v = (t < 4) ? fixed[t] : int'($urandom_range(0, 65535));
            do_load(1, v);
            wait_idle(1);
            for (int c = 0; c < 4 * PS; c++) begin
                @(negedge clk);
                s = ((k - 1) / PS) % 4;
                model(v, s, 1'b1, ean, esg, edv, eov);
                sample(1, an, sg, dv, ov, bs);
                vectors++;
                if ({an, sg, dv, ov, bs} !== {ean, esg, edv, eov, 1'b0}) begin
                    miscompares++;
                    $display("FAIL wide_scan v=%0d slot=%0d AN=%b seg=%b dv=%0d ov=%b want AN=%b seg=%b dv=%0d ov=%b",
                             v, s, an, sg, dv, ov, ean, esg, edv, eov);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] an, ean;
        logic [6:0] sg, esg;
        logic [3:0] dv, edv;
        logic ov, eov, bs;
        int s;
        do_load(0, 255);
        do_load(1, 12345);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({b8.busy, b8.overflow, b16.busy, b16.overflow} !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_reset busy8=%b ov8=%b busy16=%b ov16=%b want 0 0 0 0",
                     b8.busy, b8.overflow, b16.busy, b16.overflow);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 4 * PS + 12; c++) begin
            @(negedge clk);
            s = ((k - 1) / PS) % 4;
            for (int w = 0; w < 2; w++) begin
                model(0, s, 1'b1, ean, esg, edv, eov);
                sample(w, an, sg, dv, ov, bs);
                vectors++;
                if ({an, sg, dv, ov, bs} !== {ean, esg, edv, eov, 1'b0}) begin
                    miscompares++;
                    $display("FAIL mid_reset_scan inst=%0d slot=%0d AN=%b seg=%b dv=%0d ov=%b busy=%b",
                             w, s, an, sg, dv, ov, bs);
                end
            end
        end
    endtask

    initial begin
        set_load(0, 1'b0, 0);
        set_load(1, 1'b0, 0);
        set_load(2, 1'b0, 0);
        test_reset();
        test_conv_busy();
        test_blanking();
        test_load_ignored();
        test_overflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg7_tdm_scanner.md
Name: seg7_tdm_scanner

Overview:
Parametrised time-division-multiplexed seven-segment display driver. It accepts a binary value through a load handshake and converts it to BCD with a sequential double-dabble engine. It then scans DIGITS common-anode digits at a programmable refresh rate, with leading-zero blanking and overflow indication. It sits between user logic and the board's AN/seg pins and replaces the fixed 4-digit combinational scanner.

Parameters:
DIGITS, 4, number of digits scanned (legal 1..8)
DATA_W, 8, binary input width (legal 4..20)
PRESCALE, 16, clk cycles per digit slot (>=1; 1 = advance every cycle)
BLANK_LZ, 1, 1 = blank leading zeros, 0 = show all digits

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous reset, active-low
load  input  1  request to display data_in
data_in  input  DATA_W  unsigned binary value
busy  output  1  conversion in progress; load ignored while high
overflow  output  1  displayed value >= 10^DIGITS
AN  output  DIGITS  digit anodes, active-low, one-hot-low
seg  output  7  {g,f,e,d,c,b,a}, active-low
digit_val  output  4  BCD nibble of the currently driven slot (debug)

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous and active-low.
- Reset values: AN all ones, seg=7'b1111111, digit_val=0, busy=0, overflow=0, display BCD register=0, slot index=0, prescaler=0, conversion state IDLE.
- Reset is sampled every edge and aborts any conversion mid-flight; the display register returns to 0.
- States: IDLE, CONV.
- Load acceptance:
  - Edge where load=1 and busy=0: capture data_in into the shift register, clear scratch BCD, go to CONV, busy=1.
  - load while busy=1 is ignored; there is no queueing.
- CONV:
  - One double-dabble iteration per cycle: add 3 to every scratch nibble >=5, then shift left 1 bit.
  - Scratch BCD holds enough digits for 2^DATA_W-1, which may exceed DIGITS.
  - On the DATA_W-th iteration edge:
    - the low DIGITS nibbles are written atomically to the display register;
    - overflow is set to 1 if any scratch nibble above DIGITS-1 is nonzero, else 0;
    - busy returns to 0 and the state returns to IDLE.
  - busy is high for exactly DATA_W cycles.
  - A new load is accepted no earlier than the edge after busy falls.
  - The display never shows partial results.
- Scan:
  - The prescaler counts 0..PRESCALE-1 continuously from reset, independent of conversion.
  - At terminal count the prescaler returns to 0 and the slot index increments, wrapping DIGITS-1 -> 0.
- Outputs: AN, seg and digit_val are registered from the current slot index and display register, so they lag an index change by one cycle.
- Slot i, normal case: AN bit i=0, other bits 1; seg = decoded nibble; digit_val = nibble.
- Blanking: when BLANK_LZ=1, slot i>0 is blank if nibbles i..DIGITS-1 are all zero.
  - A blank slot drives AN=all ones and seg=7'b1111111; digit_val still shows the nibble.
  - Slot 0 is never blanked.
  - Zeros between nonzero digits are not blanked.
- Overflow: when overflow=1, every slot shows a dash (seg=7'b0111111), AN is driven normally, and blanking is disabled.
- Decode: 0..9 use standard patterns. Nibbles 10..15 cannot occur; if forced, they show all segments off.
- Simultaneous events: the slot advance and the display-register update on the same edge both take effect. The new digit value is shown from that edge's slot onward.

Test Plan:
(All scenarios use DIGITS=4, DATA_W=8, PRESCALE=4 unless stated.)
- Reset: rst_n=0 for 3 cycles -> AN=4'b1111, seg=7'b1111111, busy=0. After release, slot 0 shows AN=4'b1110, seg=7'b1000000 ('0'), and slots 1-3 are blank; each slot lasts 4 cycles.
- Load 8'd255 -> busy=1 for exactly 8 cycles. Then the scan shows slot0 '5' (7'b0010010), slot1 '5', slot2 '2' (7'b0100100), and slot3 blank (AN=4'b1111).
- Load 8'd7 -> only slot 0 lit, '7'. Load 8'd100 -> slots 0,1 show '0', slot 2 shows '1' (7'b1111001), slot 3 blank. With BLANK_LZ=0, 8'd7 shows '0','0','0','7'.
- Load 8'd200, then pulse load with 8'd50 three cycles later while busy -> display settles to 200; 50 is never shown.
- DATA_W=16: load 16'd12345 -> overflow=1, all four slots show seg=7'b0111111. Then load 16'd9999 -> overflow=0, all slots show '9'.
- Reset mid-conversion: load 8'd255, drop rst_n at cycle 4 of busy -> busy=0, display 0, overflow=0. 255 never appears.
